// File: rtl/store_rmw_unit.sv
// Sub-word store unit: sb/sh are done as read-modify-write of the containing word,
// sw is a single write. Alignment/size errors and MFC timeouts end in a one-cycle Err.
module store_rmw_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [31:0] Addr,
    input  logic [31:0] D,
    input  logic [1:0]  DT,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    output logic        MemEnable,
    output logic        MemRW,
    input  logic        MFC,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t        state_reg;
    logic [1:0]    addr_lo_reg;
    logic [31:0]   d_reg;
    logic [1:0]    dt_reg;
    logic [CW-1:0] wait_cnt_reg;

    logic          req_err;
    logic [3:0]    lane_mask;
    logic [31:0]   src_word;
    logic [31:0]   merged_word;

    assign req_err = (DT == 2'b11) ||
                     (DT == 2'b01 && Addr[0]) ||
                     (DT == 2'b10 && Addr[1:0] != 2'b00);

    // Lanes replaced by the store, and the source data replicated so that
    // every lane position already holds the right byte of D.
    always_comb begin
        lane_mask = 4'b0000;
        src_word  = d_reg;
        case (dt_reg)
            2'b00: begin
                lane_mask[addr_lo_reg] = 1'b1;
                src_word = {4{d_reg[7:0]}};
            end
            2'b01: begin
                lane_mask[{addr_lo_reg[1], 1'b0}] = 1'b1;
                lane_mask[{addr_lo_reg[1], 1'b1}] = 1'b1;
                src_word = {2{d_reg[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                src_word  = d_reg;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[8*gi +: 8] = lane_mask[gi] ? src_word[8*gi +: 8]
                                                          : MemRData[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_lo_reg  <= 2'b00;
            d_reg        <= 32'h0;
            dt_reg       <= 2'b00;
            wait_cnt_reg <= '0;
            MemAddr      <= 32'h0;
            MemWData     <= 32'h0;
            MemEnable    <= 1'b0;
            MemRW        <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Err          <= 1'b0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        addr_lo_reg  <= Addr[1:0];
                        d_reg        <= D;
                        dt_reg       <= DT;
                        MemAddr      <= {Addr[31:2], 2'b00};
                        wait_cnt_reg <= '0;
                        Busy         <= 1'b1;
                        if (req_err) begin
                            state_reg <= ERR;
                            Err       <= 1'b1;
                        end else if (DT == 2'b10) begin
                            state_reg <= WRITE;
                            MemWData  <= D;
                            MemEnable <= 1'b1;
                            MemRW     <= 1'b1;
                        end else begin
                            state_reg <= READ;
                            MemEnable <= 1'b1;
                            MemRW     <= 1'b0;
                        end
                    end
                end
                READ: begin
                    // MFC wins over a timeout in the same cycle.
                    if (MFC) begin
                        state_reg    <= WRITE;
                        MemWData     <= merged_word;
                        MemRW        <= 1'b1;
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg == LAST_WAIT) begin
                        state_reg <= ERR;
                        MemEnable <= 1'b0;
                        Err       <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CW'(1);
                    end
                end
                WRITE: begin
                    if (MFC) begin
                        state_reg <= DONE;
                        MemEnable <= 1'b0;
                        MemRW     <= 1'b0;
                        Done      <= 1'b1;
                    end else if (wait_cnt_reg == LAST_WAIT) begin
                        state_reg <= ERR;
                        MemEnable <= 1'b0;
                        MemRW     <= 1'b0;
                        Err       <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    Busy      <= 1'b0;
                end
                ERR: begin
                    state_reg <= IDLE;
                    Busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    MemEnable <= 1'b0;
                    MemRW     <= 1'b0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Randomized + directed bench for store_rmw_unit: expected memory accesses and
// Done/Err pulses are queued at issue time and compared by an independent monitor.
module tb_store_rmw_unit;

    localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [31:0] Addr = 32'h0;
    logic [31:0] D = 32'h0;
    logic [1:0]  DT = 2'b00;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData = 32'h0;
    logic        MemEnable;
    logic        MemRW;
    logic        MFC = 1'b0;
    logic        Busy;
    logic        Done;
    logic        Err;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    mfc_delay = 0;
    bit    mfc_block = 1'b0;
    int    wait_n = 0;

    store_rmw_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Addr(Addr), .D(D), .DT(DT),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData),
        .MemEnable(MemEnable), .MemRW(MemRW), .MFC(MFC),
        .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Memory side: answer an access after mfc_delay cycles; random MFC noise when idle.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            MFC = 1'b0;
            wait_n = 0;
        end else if (MemEnable && !mfc_block) begin
            if (wait_n >= mfc_delay) begin
                MFC = 1'b1;
                wait_n = 0;
            end else begin
                MFC = 1'b0;
                wait_n++;
            end
        end else begin
            MFC = MemEnable ? 1'b0 : 1'($urandom_range(0, 1));
            wait_n = 0;
        end
    end

    task automatic got(input int kind, input logic [31:0] a, input logic [31:0] d);
        item_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual kind=%0d addr=%h data=%h required none", kind, a, d);
        end else begin
            e = q.pop_front();
            $display("txn kind=%0d addr=%h data=%h", kind, a, d);
            chk("kind", 32'(kind), 32'(e.kind));
            if (kind == e.kind && (kind == K_RD || kind == K_WR))
                chk("mem_addr", a, e.addr);
            if (kind == e.kind && kind == K_WR)
                chk("mem_wdata", d, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (MemEnable && MFC)
                got(MemRW ? K_WR : K_RD, MemAddr, MemWData);
            if (Done)
                got(K_DONE, 32'h0, 32'h0);
            if (Err)
                got(K_ERR, 32'h0, 32'h0);
        end
    end

    function automatic logic [31:0] model_merge(input logic [31:0] r, input logic [31:0] d,
                                                input logic [1:0] dt, input logic [31:0] a);
        int sh;
        if (dt == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            return (r & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end else begin
            sh = a[1] ? 16 : 0;
            return (r & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        end
    endfunction

    task automatic push_expected(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] dt, input logic [31:0] rd, input bit nomfc);
        logic [31:0] wa;
        bit bad;
        wa  = a & 32'hFFFF_FFFC;
        bad = (dt == 2'b11) || (dt == 2'b01 && a % 2 == 1) || (dt == 2'b10 && a % 4 != 0);
        if (bad || nomfc) begin
            q.push_back('{K_ERR, 32'h0, 32'h0});
        end else if (dt == 2'b10) begin
            q.push_back('{K_WR, wa, d});
            q.push_back('{K_DONE, 32'h0, 32'h0});
        end else begin
            q.push_back('{K_RD, wa, 32'h0});
            q.push_back('{K_WR, wa, model_merge(rd, d, dt, a)});
            q.push_back('{K_DONE, 32'h0, 32'h0});
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (Busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (Busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle actual busy required idle within 300 cycles");
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] dt,
                         input logic [31:0] rd, input int dly, input bit nomfc,
                         input bit push, input int exp_lat, input bit poke);
        int n;
        wait_idle();
        mfc_delay = dly;
        mfc_block = nomfc;
        MemRData  = rd;
        if (push) push_expected(a, d, dt, rd, nomfc);
        Addr  = a;
        D     = d;
        DT    = dt;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        Addr  = $urandom;
        D     = $urandom;
        DT    = 2'($urandom_range(0, 3));
        if (exp_lat > 0) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(Done || Err) && n < 100);
            chk("latency", 32'(n), 32'(exp_lat));
        end else if (poke) begin
            @(negedge clk);
            if (Busy) begin
                Start = 1'b1;
                @(posedge clk);
                #1;
                Start = 1'b0;
            end
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_memenable"}, 32'(MemEnable), 32'h0);
        chk({tag, "_memrw"}, 32'(MemRW), 32'h0);
        chk({tag, "_busy"}, 32'(Busy), 32'h0);
        chk({tag, "_done"}, 32'(Done), 32'h0);
        chk({tag, "_err"}, 32'(Err), 32'h0);
        chk({tag, "_memaddr"}, MemAddr, 32'h0);
        chk({tag, "_memwdata"}, MemWData, 32'h0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #2 chk_outputs_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed examples
        issue(32'h0000_0101, 32'h0000_00AB, 2'b00, 32'h1122_3344, 0, 0, 1, 3, 0);
        issue(32'h0000_0202, 32'hFFFF_5A5A, 2'b01, 32'h1122_3344, 0, 0, 1, 3, 0);
        issue(32'h0000_0004, 32'h0000_FFFF, 2'b10, 32'h1122_3344, 0, 0, 1, 2, 0);
        issue(32'h0000_0003, 32'h1234_5678, 2'b01, 32'h0, 0, 0, 1, 1, 0);
        issue(32'h0000_0002, 32'h1234_5678, 2'b10, 32'h0, 0, 0, 1, 1, 0);
        issue(32'h0000_0000, 32'h1234_5678, 2'b11, 32'h0, 0, 0, 1, 1, 0);

        // Timeout: 16 waiting READ cycles, then Err; next sw completes normally
        issue(32'h0000_0010, 32'h0000_0055, 2'b00, 32'hCAFE_F00D, 0, 1, 1, 17, 0);
        issue(32'h0000_0008, 32'hDEAD_BEEF, 2'b10, 32'h0, 1, 0, 1, 3, 0);

        // MFC arriving in the last allowed wait cycle still succeeds
        issue(32'h0000_0031, 32'h0000_0077, 2'b00, 32'hA5A5_A5A5, 15, 0, 1, 0, 0);

        // Reset while WRITE waits for MFC
        issue(32'h0000_0020, 32'h0BAD_0BAD, 2'b10, 32'h0, 0, 1, 0, 0, 0);
        repeat (3) @(negedge clk);
        #3 reset = 1'b1;
        #1 chk_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        issue(32'h0000_0024, 32'h0000_1357, 2'b10, 32'h0, 0, 0, 1, 2, 0);

        // Randomized traffic with Start pokes while busy
        for (int i = 0; i < 60; i++) begin
            issue($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 3), 0, 1, 0, 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
STORE_RMW_UNIT -- requirements
Module: store_rmw_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port clk  input  1  clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  asynchronous active-high reset.
REQ-004 Port Start  input  1  store request; sampled only in IDLE.
REQ-005 Port Addr  input  32  byte address of the store.
REQ-006 Port D  input  32  register-file source data; the store uses its low byte, low halfword or full word.
REQ-007 Port DT  input  2  size: 00 = sb, 01 = sh, 10 = sw, 11 = illegal.
REQ-008 Port MemAddr  output  32  word-aligned memory address, {Addr[31:2], 2'b00}.
REQ-009 Port MemWData  output  32  merged write word.
REQ-010 Port MemRData  input  32  read word from memory.
REQ-011 Port MemEnable  output  1  memory request strobe.
REQ-012 Port MemRW  output  1  1 = write, 0 = read.
REQ-013 Port MFC  input  1  memory function complete; a 1-cycle pulse that ends the current access.
REQ-014 Port Busy  output  1  high in every state except IDLE.
REQ-015 Port Done  output  1  1-cycle pulse on successful completion.
REQ-016 Port Err  output  1  1-cycle pulse on misalignment, illegal DT or timeout.
REQ-017 Parameter TIMEOUT, default 16: maximum number of cycles to wait for MFC per access.

Function
REQ-018 Byte lane k SHALL be bits [8k+7:8k], little-endian, with k = Addr[1:0].
REQ-019 The FSM SHALL have exactly these states: IDLE, READ, WRITE, DONE, ERR.
REQ-020 IDLE with Start=1 SHALL capture Addr, D and DT into internal registers; later input changes SHALL have no effect until the next IDLE.
REQ-021 IDLE with Start=1 and an error condition SHALL go to ERR. Error conditions are:
- DT=11;
- DT=01 with Addr[0]=1;
- DT=10 with Addr[1:0]≠00.
REQ-022 IDLE with Start=1 and a legal request SHALL go to:
- WRITE if DT=10, with MemWData = D;
- READ if DT is 00 or 01.
REQ-023 READ SHALL drive MemEnable=1 and MemRW=0 until MFC. On the MFC cycle it SHALL latch MemRData and go to WRITE.
REQ-024 The merge SHALL be applied to the read word:
- sb: replace lane Addr[1:0] with D[7:0];
- sh: replace lanes Addr[1]*2+1 and Addr[1]*2 with D[15:0];
- all other bits keep the read value.
REQ-025 WRITE SHALL drive MemEnable=1, MemRW=1 and MemWData = merged word, held stable until MFC. On MFC it SHALL go to DONE.
REQ-026 DONE SHALL assert Done for one cycle and then return to IDLE.
REQ-027 ERR SHALL assert Err for one cycle and then return to IDLE. No memory access SHALL be issued for misaligned or illegal requests.
REQ-028 A wait counter SHALL clear on entry to READ or WRITE and increment each cycle without MFC. If it reaches TIMEOUT, the FSM SHALL drop MemEnable and go to ERR.
REQ-029 Outside READ and WRITE, MemEnable SHALL be 0; MFC SHALL be ignored.
REQ-030 Start asserted while Busy=1 SHALL be ignored and not queued. Start held high in the DONE or ERR cycle SHALL be taken on the following IDLE cycle.
REQ-031 MFC arriving in the same cycle the counter reaches TIMEOUT SHALL count as success; MFC has priority.
REQ-032 Minimum latency from Start to Done SHALL be:
- sw: 2 cycles when MFC arrives in the first WRITE cycle;
- sb/sh: 3 cycles when MFC arrives in the first cycle of each access.

Reset
REQ-033 Reset=1 SHALL immediately force:
- state IDLE;
- MemEnable, MemRW, Busy, Done and Err to 0;
- MemAddr, MemWData, the captured registers and the wait counter to 0.
REQ-034 Reset during READ or WRITE SHALL abort the access with no Done and no Err. The first Start after reset release SHALL be handled normally.

Verification
REQ-035 sb: Addr=0x00000101, D=0x000000AB, MemRData=0x11223344, MFC on first cycle of each access -> one read then one write to MemAddr=0x00000100 with MemWData=0x1122AB44, then Done.
REQ-036 sh: Addr=0x00000202, D=0xFFFF5A5A, MemRData=0x11223344 -> MemWData=0x5A5A3344, then Done.
REQ-037 sw: Addr=0x00000004, D=0x0000FFFF -> single write of 0x0000FFFF with no read cycle, Done exactly 2 cycles after Start.
REQ-038 Errors: sh with Addr=0x3, sw with Addr=0x2, and DT=11 -> each gives an Err pulse with MemEnable never asserted.
REQ-039 Timeout: sb with MFC held 0 -> MemEnable drops and Err pulses after TIMEOUT=16 wait cycles. Then a new sw with MFC completes normally.
REQ-040 Reset mid-WRITE: reset asserted while waiting for MFC -> all outputs 0 immediately, no Done. A Start after release completes correctly.
